sm2201_isa_camac_interface: RTL and testbench

ISA-bus to CAMAC bridge for the SM2201 crate controller board. It decodes 8-bit ISA I/O cycles in the window 0x100–0x13F and turns them into 16-bit CAMAC dataway read/write cycles. It inserts ISA wait states through CHRDY while a CAMAC cycle is in flight and routes the CAMAC LAM request to a selectable ISA IRQ line. It is the top of the interface board and is clocked from the ISA bus clock.

---
 rtl/sm2201_isa_camac_interface_pkg.sv | 31 +++
 rtl/sm2201_isa_camac_interface_isa_strobe_sync.sv | 33 +++
 rtl/sm2201_isa_camac_interface.sv | 194 +++++++++++++++++++
 tb/tb_sm2201_isa_camac_interface.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm2201_isa_camac_interface_pkg.sv
// Shared definitions for the SM2201 ISA-to-CAMAC bridge.
//   - I/O window geometry and special offsets
//   - status register bit positions
//   - CAMAC cycle FSM state type
//   - default acknowledge timeout
package sm2201_isa_camac_interface_pkg;

  localparam int unsigned WIN_BITS        = 6;
  localparam logic [5:0]  LAST_DATA_OFF   = 6'h3D;
  localparam logic [5:0]  CTRL_OFF        = 6'h3E;
  localparam logic [5:0]  RSVD_OFF        = 6'h3F;

  // Status byte returned at CTRL_OFF
  localparam int unsigned ST_IRQ_EN       = 0;
  localparam int unsigned ST_BUSY         = 1;
  localparam int unsigned ST_LAM          = 2;
  localparam int unsigned ST_TIMEOUT      = 3;

  // cb_addr write-flag position
  localparam int unsigned CB_WRITE_BIT    = 5;

  localparam int unsigned ACK_TIMEOUT_DEF = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StDone
  } cyc_state_e;

endpackage

// File: rtl/sm2201_isa_camac_interface_isa_strobe_sync.sv
// Two-flop synchronizer with falling-edge detector for an asynchronous,
// active-low strobe.
//   clk_i   : sampling clock
//   rst_ni  : synchronous active-low reset (chain resets to the inactive 1)
//   d_i     : asynchronous input
//   level_o : synchronized level
//   fall_o  : one-clock pulse on a synchronized 1->0 transition
module isa_strobe_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/sm2201_isa_camac_interface.sv
// SM2201 ISA-to-CAMAC bridge. Decodes 8-bit ISA I/O cycles in a 64-byte
// window into 16-bit CAMAC dataway cycles, stretches the ISA cycle with
// isa_chrdy while CAMAC is busy, and routes LAM to a selectable IRQ line.
//   isa_*  : ISA bus side (strobes active-low, isa_chrdy 0 = wait)
//   cb_*   : CAMAC dataway side (cb_cx1 strobe, cb_zk4 ack, cb_prr LAM)
//   Window layout: 0x00-0x3D data bytes (word n = off[5:1]), 0x3E control
//   / status, 0x3F reserved (reads 0).
module sm2201_isa_camac_interface
  import sm2201_isa_camac_interface_pkg::*;
#(
  parameter logic [9:0]  BASE_ADDR   = 10'h100,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic        isa_clk,
  input  logic        isa_reset,
  input  logic        isa_ior,
  input  logic        isa_iow,
  input  logic [9:0]  isa_addr,
  input  logic        isa_ale,
  input  logic        isa_aen,
  inout  wire  [7:0]  isa_data,
  output logic        isa_chrdy,
  output logic [7:0]  isa_irq,
  input  logic        cb_prr,
  input  logic        cb_zk4,
  output logic        cb_cx1,
  output logic [11:0] cb_addr,
  inout  wire  [15:0] cb_data
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  cyc_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]  addr_q;
  logic [11:0] cb_addr_q;
  logic        cyc_wr_q;
  logic [3:0]  ctrl_q;
  logic [15:0] rd_q, wr_q;
  logic        tmo_flag_q;
  logic        st_clr_pend_q;
  logic        tmo_ev;

  logic ior_lvl, ior_fall, iow_lvl, iow_fall, prr_lvl, prr_fall;

  isa_strobe_sync u_sync_ior (
    .clk_i   (isa_clk),
    .rst_ni  (isa_reset),
    .d_i     (isa_ior),
    .level_o (ior_lvl),
    .fall_o  (ior_fall)
  );

  isa_strobe_sync u_sync_iow (
    .clk_i   (isa_clk),
    .rst_ni  (isa_reset),
    .d_i     (isa_iow),
    .level_o (iow_lvl),
    .fall_o  (iow_fall)
  );

  isa_strobe_sync u_sync_prr (
    .clk_i   (isa_clk),
    .rst_ni  (isa_reset),
    .d_i     (cb_prr),
    .level_o (prr_lvl),
    .fall_o  (prr_fall)
  );

  logic unused_sync;
  assign unused_sync = iow_lvl ^ prr_fall;

  logic       lam;
  logic       hit;
  logic [5:0] off;
  logic       is_data;
  logic       start, rd_start, wr_start, camac_rd, camac_wr;

  assign lam      = ~prr_lvl;
  assign hit      = ~isa_aen & (addr_q[9:WIN_BITS] == BASE_ADDR[9:WIN_BITS]);
  assign off      = addr_q[WIN_BITS-1:0];
  assign is_data  = (off <= LAST_DATA_OFF);
  // Only one strobe edge at a time, only in the window, only when idle.
  assign start    = (state_q == StIdle) & hit & (ior_fall ^ iow_fall);
  assign rd_start = start & ior_fall;
  assign wr_start = start & iow_fall;
  assign camac_rd = rd_start & is_data & ~off[0];
  assign camac_wr = wr_start & is_data & off[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_ev  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (camac_rd || camac_wr) state_d = StSetup;
      end
      StSetup: begin
        state_d = StStrobe;
        cnt_d   = '0;
      end
      StStrobe: begin
        if (!cb_zk4) begin
          state_d = StDone;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_d = StDone;
          tmo_ev  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge isa_clk) begin
    if (!isa_reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      addr_q        <= '0;
      cb_addr_q     <= '0;
      cyc_wr_q      <= 1'b0;
      ctrl_q        <= '0;
      rd_q          <= '0;
      wr_q          <= '0;
      tmo_flag_q    <= 1'b0;
      st_clr_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (isa_ale) addr_q <= isa_addr;

      if (camac_rd || camac_wr) begin
        cb_addr_q <= {6'b0, camac_wr, off[5:1]};
        cyc_wr_q  <= camac_wr;
      end

      if (wr_start && is_data) begin
        if (off[0]) wr_q[15:8] <= isa_data;
        else        wr_q[7:0]  <= isa_data;
      end
      if (wr_start && off == CTRL_OFF) ctrl_q <= isa_data[3:0];

      // The status flag is cleared when the status read ends, so the host
      // still sees it for the whole strobe.
      if (rd_start && off == CTRL_OFF) st_clr_pend_q <= 1'b1;
      if (st_clr_pend_q && ior_lvl) begin
        st_clr_pend_q <= 1'b0;
        tmo_flag_q    <= 1'b0;
      end

      // Read data is latched on the way into DONE while the slave still
      // drives the dataway (it releases once cb_cx1 rises).
      if (state_q == StStrobe && state_d == StDone) begin
        if (tmo_ev)    tmo_flag_q <= 1'b1;
        if (!cyc_wr_q) rd_q       <= tmo_ev ? 16'hFFFF : cb_data;
      end
    end
  end

  logic       busy;
  logic       cb_drive;
  logic [7:0] status;
  logic [7:0] rd_byte;

  assign busy     = (state_q != StIdle);
  assign cb_drive = cyc_wr_q & ((state_q == StSetup) | (state_q == StStrobe));

  always_comb begin
    status              = '0;
    status[ST_IRQ_EN]   = ctrl_q[3];
    status[ST_BUSY]     = busy;
    status[ST_LAM]      = lam;
    status[ST_TIMEOUT]  = tmo_flag_q;
  end

  always_comb begin
    rd_byte = '0;
    if (is_data)              rd_byte = off[0] ? rd_q[15:8] : rd_q[7:0];
    else if (off == CTRL_OFF) rd_byte = status;
    else if (off == RSVD_OFF) rd_byte = '0;
  end

  assign isa_data  = (hit && !isa_ior) ? rd_byte : 8'hzz;
  assign cb_data   = cb_drive ? wr_q : 16'hzzzz;
  assign isa_chrdy = ~((state_q == StSetup) | (state_q == StStrobe));
  assign cb_cx1    = ~(state_q == StStrobe);
  assign cb_addr   = cb_addr_q;
  assign isa_irq   = (ctrl_q[3] && lam) ? 8'(8'd1 << ctrl_q[2:0]) : 8'h00;

endmodule

// File: tb/tb_sm2201_isa_camac_interface.sv
// Randomized self-checking bench for sm2201_isa_camac_interface with an
// abstract model of the register map and CAMAC cycle timing.
module tb_sm2201_isa_camac_interface;

  localparam int         T    = 8;
  localparam logic [9:0] BASE = 10'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ior = 1'b1, iow = 1'b1, ale = 1'b0, aen = 1'b0;
  logic [9:0]  addr = '0;
  logic        prr = 1'b1;
  logic        zk4 = 1'b1;
  logic        chrdy, cx1;
  logic [7:0]  irq;
  logic [11:0] caddr;
  tri1  [7:0]  isa_data;
  tri1  [15:0] cb_data;

  logic        isa_drv = 1'b0;
  logic [7:0]  isa_val = '0;
  logic        sl_ack_en = 1'b1;
  int          sl_delay = 2;
  logic [15:0] sl_rdata = '0;
  int          sl_cnt = 0;

  assign isa_data = isa_drv ? isa_val : 8'hzz;
  assign cb_data  = (!cx1 && !caddr[5]) ? sl_rdata : 16'hzzzz;

  sm2201_isa_camac_interface #(
    .BASE_ADDR   (BASE),
    .ACK_TIMEOUT (T)
  ) dut (
    .isa_clk   (clk),
    .isa_reset (rst_n),
    .isa_ior   (ior),
    .isa_iow   (iow),
    .isa_addr  (addr),
    .isa_ale   (ale),
    .isa_aen   (aen),
    .isa_data  (isa_data),
    .isa_chrdy (chrdy),
    .isa_irq   (irq),
    .cb_prr    (prr),
    .cb_zk4    (zk4),
    .cb_cx1    (cx1),
    .cb_addr   (caddr),
    .cb_data   (cb_data)
  );

  always #5 clk = ~clk;

  // CAMAC slave plus bus monitor, sampled on the falling edge.
  int unsigned mon_pulses = 0, mon_low = 0;
  logic [11:0] mon_caddr = '0;
  logic [15:0] mon_cdata = '0;
  logic        prev_cx1 = 1'b1;

  always @(negedge clk) begin
    if (!chrdy) mon_low++;
    if (!cx1) begin
      if (prev_cx1) mon_pulses++;
      mon_caddr = caddr;
      mon_cdata = cb_data;
      sl_cnt++;
      if (sl_ack_en && sl_cnt >= sl_delay) zk4 = 1'b0;
    end else begin
      sl_cnt = 0;
      zk4    = 1'b1;
    end
    prev_cx1 = cx1;
  end

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [15:0] m_wr = '0, m_rd = '0;
  logic [3:0]  m_ctrl = '0;
  logic        m_tflag = 1'b0;

  function automatic logic [7:0] exp_irq();
    return (m_ctrl[3] && !prr) ? 8'(8'd1 << m_ctrl[2:0]) : 8'h00;
  endfunction

  task automatic bus_op(input string tag, input bit rd, input logic [9:0] a, input bit aen_v,
                        input logic [7:0] wv, input bit ack_en, input int delay,
                        input logic [15:0] rdata);
    logic [5:0]  o;
    bit          hit, camac, clr_after;
    int          exp_pulses, exp_low, strobe_clks;
    logic [7:0]  exp_byte;
    logic [11:0] exp_caddr;
    int unsigned p0, l0;
    o          = a[5:0];
    hit        = !aen_v && (a[9:6] == BASE[9:6]);
    camac      = 1'b0;
    clr_after  = 1'b0;
    exp_byte   = 8'hFF;
    exp_caddr  = '0;
    // CAMAC cycle: one SETUP clock plus the acknowledge wait (ack wins on
    // the last timeout clock), capped at T clocks.
    strobe_clks = (ack_en && delay <= T) ? delay : T;
    if (hit) begin
      if (rd) begin
        if (o <= 6'h3D) begin
          if (!o[0]) begin
            camac     = 1'b1;
            exp_caddr = {7'b0, o[5:1]};
            if (ack_en && delay <= T) m_rd = rdata;
            else begin
              m_rd = 16'hFFFF;
              m_tflag = 1'b1;
            end
            exp_byte = m_rd[7:0];
          end else begin
            exp_byte = m_rd[15:8];
          end
        end else if (o == 6'h3E) begin
          exp_byte  = {4'b0, m_tflag, !prr, 1'b0, m_ctrl[3]};
          clr_after = 1'b1;
        end else begin
          exp_byte = 8'h00;
        end
      end else begin
        if (o <= 6'h3D) begin
          if (!o[0]) m_wr[7:0] = wv;
          else begin
            m_wr[15:8] = wv;
            camac      = 1'b1;
            exp_caddr  = {6'b0, 1'b1, o[5:1]};
            if (!(ack_en && delay <= T)) m_tflag = 1'b1;
          end
        end else if (o == 6'h3E) begin
          m_ctrl = wv[3:0];
        end
      end
    end
    exp_pulses = camac ? 1 : 0;
    exp_low    = camac ? 1 + strobe_clks : 0;

    addr = a;
    ale  = 1'b1;
    @(posedge clk);
    #1 ale = 1'b0;
    aen       = aen_v;
    sl_ack_en = ack_en;
    sl_delay  = delay;
    sl_rdata  = rdata;
    p0 = mon_pulses;
    l0 = mon_low;
    if (rd) ior = 1'b0;
    else begin
      isa_drv = 1'b1;
      isa_val = wv;
      iow     = 1'b0;
    end
    repeat (T + 12) @(posedge clk);
    @(negedge clk);
    if (rd) check_eq({tag, "_rdbyte"}, 16'(isa_data), 16'(exp_byte));
    ior     = 1'b1;
    iow     = 1'b1;
    isa_drv = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    aen = 1'b0;
    if (clr_after) m_tflag = 1'b0;
    check_eq({tag, "_pulses"}, 16'(mon_pulses - p0), 16'(exp_pulses));
    check_eq({tag, "_chrdy_low"}, 16'(mon_low - l0), 16'(exp_low));
    if (camac) check_eq({tag, "_caddr"}, 16'(mon_caddr), 16'(exp_caddr));
    if (camac && !rd) check_eq({tag, "_cdata"}, mon_cdata, m_wr);
    check_eq({tag, "_irq"}, 16'(irq), 16'(exp_irq()));
    if (rd) check_eq({tag, "_hiz"}, 16'(isa_data), 16'h00FF);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_cx1", 16'(cx1), 16'd1);
    check_eq("rst_chrdy", 16'(chrdy), 16'd1);
    check_eq("rst_irq", 16'(irq), 16'd0);
    check_eq("rst_caddr", 16'(caddr), 16'd0);
    check_eq("rst_cbdata", cb_data, 16'hFFFF);
    check_eq("rst_isadata", 16'(isa_data), 16'h00FF);

    // Directed reads
    bus_op("rd100", 1, 10'h100, 0, 8'h00, 1, 2, 16'h4208);
    bus_op("rd101", 1, 10'h101, 0, 8'h00, 1, 2, 16'h0000);
    // Decode misses (rd_q low byte is 0x08, distinct from bus pull-up)
    bus_op("aen", 1, 10'h100, 1, 8'h00, 1, 2, 16'h1111);
    bus_op("a0f0", 1, 10'h0F0, 0, 8'h00, 1, 2, 16'h2222);
    bus_op("a140", 1, 10'h140, 0, 8'h00, 1, 2, 16'h3333);
    bus_op("w140", 0, 10'h141, 0, 8'h77, 1, 2, 16'h0000);
    // Directed writes
    bus_op("wr102", 0, 10'h102, 0, 8'h34, 1, 2, 16'h0000);
    bus_op("wr103", 0, 10'h103, 0, 8'h12, 1, 2, 16'h0000);
    // Timeout and status
    bus_op("tmo104", 1, 10'h104, 0, 8'h00, 0, 0, 16'h5555);
    bus_op("st1", 1, 10'h13E, 0, 8'h00, 1, 2, 16'h0000);
    bus_op("st2", 1, 10'h13E, 0, 8'h00, 1, 2, 16'h0000);
    bus_op("rsvd", 1, 10'h13F, 0, 8'h00, 1, 2, 16'h0000);
    // IRQ routing
    bus_op("ctrl", 0, 10'h13E, 0, 8'h0D, 1, 2, 16'h0000);
    prr = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("irq_on", 16'(irq), 16'h0020);
    prr = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("irq_off", 16'(irq), 16'h0000);

    // Reset in the middle of a CAMAC write strobe
    addr = 10'h105;
    ale  = 1'b1;
    @(posedge clk);
    #1 ale = 1'b0;
    sl_ack_en = 1'b0;
    isa_drv   = 1'b1;
    isa_val   = 8'h5A;
    iow       = 1'b0;
    for (int k = 0; k < 20 && cx1; k++) @(negedge clk);
    check_eq("mid_strobe", 16'(cx1), 16'd0);
    rst_n   = 1'b0;
    iow     = 1'b1;
    isa_drv = 1'b0;
    @(negedge clk);
    check_eq("mrst_cx1", 16'(cx1), 16'd1);
    check_eq("mrst_chrdy", 16'(chrdy), 16'd1);
    check_eq("mrst_cbdata", cb_data, 16'hFFFF);
    check_eq("mrst_caddr", 16'(caddr), 16'd0);
    check_eq("mrst_irq", 16'(irq), 16'd0);
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    m_wr    = '0;
    m_rd    = '0;
    m_ctrl  = '0;
    m_tflag = 1'b0;
    @(negedge clk);
    bus_op("post_st", 1, 10'h13E, 0, 8'h00, 1, 2, 16'h0000);
    bus_op("post_rd", 1, 10'h101, 0, 8'h00, 1, 2, 16'h0000);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      logic [9:0] a;
      bit         rd, aen_v, ack_en;
      int         dly;
      a      = ($urandom_range(0, 9) < 7) ? (BASE | 10'($urandom_range(0, 63)))
                                          : 10'($urandom);
      rd     = $urandom_range(0, 1) == 1;
      aen_v  = $urandom_range(0, 9) == 0;
      ack_en = $urandom_range(0, 9) < 8;
      dly    = $urandom_range(1, T + 2);
      prr    = $urandom_range(0, 1) == 1;
      bus_op($sformatf("rnd%0d", i), rd, a, aen_v, 8'($urandom), ack_en, dly,
             16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
